assoc_layer_controller: RTL and testbench
=========================================

# assoc_layer_controller

Responder side of the memory-layer/associative-layer learning handshake in the GAM datapath. The memory-layer controller asserts `assoc_learning_start` after it finishes a learning step. This block then records or strengthens the key→response association in an internal edge table and returns a one-cycle `assoc_learning_done`. A read-only edge port exposes the table to recall logic and to the bench.

## Interface
- NODE_W, 8, width of key/response node indices
- WEIGHT_W, 8, width of association weight (saturating)
- DEPTH, 16, number of edge-table entries (power of two, ≥2); ADDR_W = $clog2(DEPTH)
- clk  in  1  clock (all state updates on rising edge)
- reset  in  1  synchronous, active-high
- assoc_learning_start  in  1  level request; held high by the requester until it sees done
- key_node  in  NODE_W  winner node of key class; sampled with start
- resp_node  in  NODE_W  winner node of response class; sampled with start
- assoc_learning_done  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- edge_count  out  ADDR_W+1  number of valid entries
- last_hit  out  1  last operation found an existing edge
- last_replaced  out  1  last operation evicted a valid entry
- rd_addr  in  ADDR_W  edge read address
- rd_valid / rd_key / rd_resp / rd_weight  out  1/NODE_W/NODE_W/WEIGHT_W  combinational contents of entry rd_addr

## Operation
- Edge table: DEPTH entries of {valid, key, resp, weight}.
- FSM states and transitions:
  - IDLE: on start=1, latch key_node/resp_node, clear scan state, go to SCAN with idx=0.
  - SCAN: one entry per cycle for exactly DEPTH cycles; go to UPDATE when idx=DEPTH-1.
  - UPDATE: one cycle, then DONE.
  - DONE: one cycle, done=1, then RELEASE.
  - RELEASE: wait while start=1; go to IDLE when start=0.
- SCAN always covers the full table and tracks three things:
  - hit_idx: valid entry with key and resp equal to the latched values.
  - free_idx: lowest-index invalid entry.
  - victim_idx: lowest-index valid entry of minimum weight.
- UPDATE applies exactly one of:
  - Hit: weight+1, saturating at 2^WEIGHT_W−1.
  - No hit, free entry exists: write {1, key, resp, weight=1} at free_idx.
  - No hit, table full: overwrite victim_idx with {1, key, resp, 1}.
- UPDATE also sets the status outputs:
  - last_hit = 1 on a hit, otherwise 0.
  - last_replaced = 1 only on the full-table overwrite.
  - edge_count increments only on a free-entry write.
- Table writes occur only in UPDATE, plus SCAN when ASSOC_DECAY_EN is defined. The rd port never stalls.

## Timing
- Reset values:
  - state=IDLE; all entries valid=0, key=0, resp=0, weight=0.
  - done=0, busy=0, edge_count=0, last_hit=0, last_replaced=0.
- Define cycle 0 as the cycle in which IDLE samples start=1.
  - SCAN occupies cycles 1..DEPTH.
  - UPDATE is cycle DEPTH+1; its write is visible on rd port from cycle DEPTH+2.
  - done=1 in cycle DEPTH+2 only. Total latency is DEPTH+2 cycles.
- busy is 1 in cycles 1..DEPTH+2.
- start dropping mid-operation is ignored: the operation completes, done still pulses, RELEASE exits on its first cycle.
- start still high after done does not trigger a second operation: RELEASE blocks it until start has been low for one cycle.
- key_node/resp_node changes after cycle 0 have no effect.
- Reset asserted in any state: next cycle is IDLE, table cleared, no done pulse, and any in-flight update is discarded.

## Configuration
- ASSOC_DECAY_EN defined:
  - During SCAN, each valid entry with key equal to the latched key and resp different has its weight decremented by 1 in that entry's scan cycle.
  - An entry decremented to 0 is invalidated in the same write and edge_count decrements.
  - Invalidated entries are eligible as free_idx in the same operation (free_idx is evaluated on post-decay state).
- ASSOC_DECAY_EN not defined: no SCAN writes; non-matching entries are never modified.

## Test plan
- DEPTH=4, reset then start with key=3, resp=7 → done exactly at cycle 6; rd_addr=0 shows valid=1, key=3, resp=7, weight=1; edge_count=1; last_hit=0.
- Repeat key=3, resp=7 three more times → entry 0 weight=4, last_hit=1, edge_count stays 1. With WEIGHT_W=2 and 5 repeats, weight saturates at 3.
- Fill 4 distinct pairs with weights {2,1,1,3} on entries 0..3, then new pair 9→9 → entry 1 (lowest-index minimum) overwritten with weight=1; last_replaced=1; edge_count stays 4.
- Hold start high for 20 cycles after done → exactly one done pulse. Drop start at cycle 2 → done still at cycle 6.
- Assert reset at cycle 3 of an operation → no done, table empty, edge_count=0, next start behaves as first insert.
- With ASSOC_DECAY_EN and entries 3→7 (w=1) and 3→8 (w=2), learn 3→8 → 3→7 invalidated, 3→8 weight=3, edge_count=1.

Source files
------------

// File: rtl/assoc_layer_controller.sv
// assoc_layer_controller: responder side of the memory/associative-layer learning
// handshake. Scans an edge table, then strengthens, inserts or replaces one
// key->response association and pulses assoc_learning_done.
// Optional feature macro: ASSOC_DECAY_EN (decays competing edges of the same key
// during the scan).
module assoc_layer_controller #(
    parameter int unsigned NODE_W   = 8,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       assoc_learning_start,
    input  logic [NODE_W-1:0]          key_node,
    input  logic [NODE_W-1:0]          resp_node,
    output logic                       assoc_learning_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     edge_count,
    output logic                       last_hit,
    output logic                       last_replaced,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic                       rd_valid,
    output logic [NODE_W-1:0]          rd_key,
    output logic [NODE_W-1:0]          rd_resp,
    output logic [WEIGHT_W-1:0]        rd_weight
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_UPDATE,
        ST_DONE,
        ST_RELEASE
    } state_e;

    state_e                 state_q;
    logic [ADDR_W-1:0]      idx_q;
    logic [NODE_W-1:0]      lkey_q;
    logic [NODE_W-1:0]      lresp_q;
    logic                   hit_found_q;
    logic [ADDR_W-1:0]      hit_idx_q;
    logic                   free_found_q;
    logic [ADDR_W-1:0]      free_idx_q;
    logic                   vict_found_q;
    logic [ADDR_W-1:0]      vict_idx_q;
    logic [WEIGHT_W-1:0]    vict_w_q;
    logic                   done_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       count_q;
    logic                   last_hit_q;
    logic                   last_repl_q;

    logic                   tbl_valid_q  [DEPTH];
    logic [NODE_W-1:0]      tbl_key_q    [DEPTH];
    logic [NODE_W-1:0]      tbl_resp_q   [DEPTH];
    logic [WEIGHT_W-1:0]    tbl_weight_q [DEPTH];

    logic                   key_match_c;
    logic                   resp_match_c;
    logic                   scan_valid_c;
    logic [WEIGHT_W-1:0]    scan_weight_c;
`ifdef ASSOC_DECAY_EN
    logic                   decay_c;
`endif

    // Entry under scan, as it looks after any decay applied this cycle
    always_comb begin
        key_match_c   = (tbl_key_q[idx_q] == lkey_q);
        resp_match_c  = (tbl_resp_q[idx_q] == lresp_q);
        scan_valid_c  = tbl_valid_q[idx_q];
        scan_weight_c = tbl_weight_q[idx_q];
`ifdef ASSOC_DECAY_EN
        decay_c = tbl_valid_q[idx_q] && key_match_c && !resp_match_c;
        if (decay_c) begin
            scan_weight_c = tbl_weight_q[idx_q] - WEIGHT_W'(1);
            if (scan_weight_c == '0) begin
                scan_valid_c = 1'b0;
            end
        end
`endif
    end

    // Handshake FSM, scan bookkeeping, table update and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            lkey_q       <= '0;
            lresp_q      <= '0;
            hit_found_q  <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            vict_found_q <= 1'b0;
            vict_idx_q   <= '0;
            vict_w_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            count_q      <= '0;
            last_hit_q   <= 1'b0;
            last_repl_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_valid_q[i]  <= 1'b0;
                tbl_key_q[i]    <= '0;
                tbl_resp_q[i]   <= '0;
                tbl_weight_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (assoc_learning_start) begin
                        lkey_q       <= key_node;
                        lresp_q      <= resp_node;
                        idx_q        <= '0;
                        hit_found_q  <= 1'b0;
                        free_found_q <= 1'b0;
                        vict_found_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
`ifdef ASSOC_DECAY_EN
                    if (decay_c) begin
                        tbl_weight_q[idx_q] <= scan_weight_c;
                        tbl_valid_q[idx_q]  <= scan_valid_c;
                        if (!scan_valid_c) begin
                            count_q <= count_q - CNT_W'(1);
                        end
                    end
`endif
                    if (scan_valid_c && key_match_c && resp_match_c) begin
                        hit_found_q <= 1'b1;
                        hit_idx_q   <= idx_q;
                    end
                    if (!scan_valid_c && !free_found_q) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    // Strict less-than keeps the lowest index among equal minima
                    if (scan_valid_c && (!vict_found_q || scan_weight_c < vict_w_q)) begin
                        vict_found_q <= 1'b1;
                        vict_idx_q   <= idx_q;
                        vict_w_q     <= scan_weight_c;
                    end
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                ST_UPDATE: begin
                    if (hit_found_q) begin
                        if (tbl_weight_q[hit_idx_q] != '1) begin
                            tbl_weight_q[hit_idx_q] <= tbl_weight_q[hit_idx_q] + WEIGHT_W'(1);
                        end
                        last_hit_q  <= 1'b1;
                        last_repl_q <= 1'b0;
                    end else if (free_found_q) begin
                        tbl_valid_q[free_idx_q]  <= 1'b1;
                        tbl_key_q[free_idx_q]    <= lkey_q;
                        tbl_resp_q[free_idx_q]   <= lresp_q;
                        tbl_weight_q[free_idx_q] <= WEIGHT_W'(1);
                        count_q     <= count_q + CNT_W'(1);
                        last_hit_q  <= 1'b0;
                        last_repl_q <= 1'b0;
                    end else begin
                        tbl_valid_q[vict_idx_q]  <= 1'b1;
                        tbl_key_q[vict_idx_q]    <= lkey_q;
                        tbl_resp_q[vict_idx_q]   <= lresp_q;
                        tbl_weight_q[vict_idx_q] <= WEIGHT_W'(1);
                        last_hit_q  <= 1'b0;
                        last_repl_q <= 1'b1;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!assoc_learning_start) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign assoc_learning_done = done_q;
    assign busy                = busy_q;
    assign edge_count          = count_q;
    assign last_hit            = last_hit_q;
    assign last_replaced       = last_repl_q;

    // Non-stalling read port
    assign rd_valid  = tbl_valid_q[rd_addr];
    assign rd_key    = tbl_key_q[rd_addr];
    assign rd_resp   = tbl_resp_q[rd_addr];
    assign rd_weight = tbl_weight_q[rd_addr];

endmodule

// File: tb/tb_assoc_layer_controller.sv
// Scoreboard bench for assoc_layer_controller (DEPTH=4, WEIGHT_W=3).
module tb_assoc_layer_controller;

    localparam int unsigned NODE_W   = 8;
    localparam int unsigned WEIGHT_W = 3;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AW       = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [NODE_W-1:0]   key_node;
    logic [NODE_W-1:0]   resp_node;
    logic                done;
    logic                busy;
    logic [AW:0]         edge_count;
    logic                last_hit;
    logic                last_replaced;
    logic [AW-1:0]       rd_addr;
    logic                rd_valid;
    logic [NODE_W-1:0]   rd_key;
    logic [NODE_W-1:0]   rd_resp;
    logic [WEIGHT_W-1:0] rd_weight;

    assoc_layer_controller #(
        .NODE_W  (NODE_W),
        .WEIGHT_W(WEIGHT_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .assoc_learning_start(start),
        .key_node            (key_node),
        .resp_node           (resp_node),
        .assoc_learning_done (done),
        .busy                (busy),
        .edge_count          (edge_count),
        .last_hit            (last_hit),
        .last_replaced       (last_replaced),
        .rd_addr             (rd_addr),
        .rd_valid            (rd_valid),
        .rd_key              (rd_key),
        .rd_resp             (rd_resp),
        .rd_weight           (rd_weight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic hit;
        logic repl;
        int   count;
        int   t0;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_pulses = 0;
    int   ops_issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_pulses++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done at t=%0t: got 1 expected 0", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_latency", 32'(cyc - e.t0), 32'(DEPTH + 2));
                chk("last_hit", 32'(last_hit), 32'(e.hit));
                chk("last_replaced", 32'(last_replaced), 32'(e.repl));
                chk("edge_count", 32'(edge_count), 32'(e.count));
                chk("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic check_entry(input int a, input logic v, input int k, input int r, input int w);
        rd_addr = AW'(a);
        #1;
        chk($sformatf("e%0d_valid", a), 32'(rd_valid), 32'(v));
        if (v) begin
            chk($sformatf("e%0d_key", a), 32'(rd_key), 32'(k));
            chk($sformatf("e%0d_resp", a), 32'(rd_resp), 32'(r));
            chk($sformatf("e%0d_weight", a), 32'(rd_weight), 32'(w));
        end
    endtask

    // One learning handshake; hold = extra cycles start stays high after done,
    // drop = cycle in which start is released early (0 = never)
    task automatic do_op(input int k, input int r, input logic eh, input logic er,
                         input int ec, input int hold, input int drop);
        exp_t e;
        bit   seen;
        @(negedge clk);
        key_node  = NODE_W'(k);
        resp_node = NODE_W'(r);
        start     = 1'b1;
        e.hit = eh; e.repl = er; e.count = ec; e.t0 = cyc;
        exp_q.push_back(e);
        ops_issued++;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                key_node  = ~NODE_W'(k);
                resp_node = ~NODE_W'(r);
            end
            if (drop > 0 && i == drop) start = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; key_node = '0; resp_node = '0; rd_addr = '0;
        do_reset();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(edge_count), 32'd0);
        chk("rst_hit", 32'(last_hit), 32'd0);
        chk("rst_repl", 32'(last_replaced), 32'd0);
        for (int a = 0; a < int'(DEPTH); a++) check_entry(a, 1'b0, 0, 0, 0);

`ifndef ASSOC_DECAY_EN
        // First insert, then strengthen and saturate
        do_op(3, 7, 1'b0, 1'b0, 1, 0, 0);
        check_entry(0, 1'b1, 3, 7, 1);
        for (int n = 0; n < 3; n++) do_op(3, 7, 1'b1, 1'b0, 1, 0, 0);
        check_entry(0, 1'b1, 3, 7, 4);
        do_op(3, 8, 1'b0, 1'b0, 2, 0, 0);
        check_entry(1, 1'b1, 3, 8, 1);
        check_entry(0, 1'b1, 3, 7, 4);
        for (int n = 0; n < 4; n++) do_op(3, 7, 1'b1, 1'b0, 2, 0, 0);
        check_entry(0, 1'b1, 3, 7, 7);

        // Fill to weights {2,1,1,3}, then replace lowest-index minimum
        do_reset();
        chk("rst2_count", 32'(edge_count), 32'd0);
        check_entry(0, 1'b0, 0, 0, 0);
        do_op(1, 1, 1'b0, 1'b0, 1, 0, 0);
        do_op(1, 1, 1'b1, 1'b0, 1, 0, 0);
        do_op(2, 2, 1'b0, 1'b0, 2, 0, 0);
        do_op(4, 4, 1'b0, 1'b0, 3, 0, 0);
        do_op(5, 5, 1'b0, 1'b0, 4, 0, 0);
        do_op(5, 5, 1'b1, 1'b0, 4, 0, 0);
        do_op(5, 5, 1'b1, 1'b0, 4, 0, 0);
        do_op(9, 9, 1'b0, 1'b1, 4, 0, 0);
        check_entry(0, 1'b1, 1, 1, 2);
        check_entry(1, 1'b1, 9, 9, 1);
        check_entry(2, 1'b1, 4, 4, 1);
        check_entry(3, 1'b1, 5, 5, 3);

        // Start held long after done, and start dropped at cycle 2
        do_op(1, 1, 1'b1, 1'b0, 4, 20, 0);
        check_entry(0, 1'b1, 1, 1, 3);
        do_op(4, 4, 1'b1, 1'b0, 4, 0, 2);
        check_entry(2, 1'b1, 4, 4, 2);

        // Reset at cycle 3 of an operation discards it
        @(negedge clk);
        key_node = 8'd7; resp_node = 8'd7; start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_count", 32'(edge_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < int'(DEPTH); a++) check_entry(a, 1'b0, 0, 0, 0);
        do_op(3, 7, 1'b0, 1'b0, 1, 0, 0);
        check_entry(0, 1'b1, 3, 7, 1);
`else
        // Competing response of the same key decays and is invalidated
        do_op(3, 8, 1'b0, 1'b0, 1, 0, 0);
        do_op(3, 8, 1'b1, 1'b0, 1, 0, 0);
        do_op(3, 8, 1'b1, 1'b0, 1, 0, 0);
        do_op(3, 7, 1'b0, 1'b0, 2, 0, 0);
        check_entry(0, 1'b1, 3, 8, 2);
        check_entry(1, 1'b1, 3, 7, 1);
        do_op(3, 8, 1'b1, 1'b0, 1, 0, 0);
        check_entry(0, 1'b1, 3, 8, 3);
        check_entry(1, 1'b0, 0, 0, 0);
`endif

        repeat (5) @(negedge clk);
        chk("done_pulses", 32'(done_pulses), 32'(ops_issued));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
